ro_freq_counter: RTL and testbench

// Measures the frequency of a free-running ring-oscillator output (outclk of an RO sensor instance).

---
 rtl/ro_freq_counter.sv | 162 ++++++++++++++++
 tb/tb_ro_freq_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronised rising edges of
// ro_in over a gate window of GATE_CYCLES clocks and reports the count.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   ro_in        ring-oscillator output, asynchronous to clk
//   start        pulse, begins a measurement when idle
//   stop         pulse, aborts a running measurement
//   continuous   re-arm automatically after each window (sampled in DONE)
//   busy         high while in GATE or DONE
//   count_valid  one-cycle pulse, count_out/overflow hold a new result
//   count_out    edges counted in the last completed window
//   overflow     edge counter saturated in the last completed window

module ro_freq_counter #(
    parameter int GATE_CYCLES = 100000,
    parameter int GATE_W      = 32,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    output logic             busy,
    output logic             count_valid,
    output logic [CNT_W-1:0] count_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t state;
    state_t state_nxt;

    logic s1;
    logic s2;
    logic s3;
    logic rise;

    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  edge_inc;
    logic              ovf;
    logic              ovf_inc;
    logic              last;
    logic              clear;
    logic              close;

    // Synchroniser runs in every state so a level already high at start
    // is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ro_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign last = (gate_cnt == GATE_LAST);

    // Saturating edge count including this cycle's edge.
    always_comb begin
        edge_inc = edge_cnt;
        ovf_inc  = ovf;
        if (rise) begin
            if (edge_cnt == CNT_MAX) begin
                ovf_inc = 1'b1;
            end else begin
                edge_inc = edge_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        close     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = GATE;
                    clear     = 1'b1;
                end
            end
            GATE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                    close     = 1'b1;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_nxt = GATE;
                    clear     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else if (clear) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= edge_inc;
            ovf      <= ovf_inc;
        end
    end

    // The result is loaded on the edge that enters DONE, so count_out and
    // overflow already carry the new value during the count_valid cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_valid <= 1'b0;
            count_out   <= '0;
            overflow    <= 1'b0;
        end else begin
            count_valid <= close;
            if (close) begin
                count_out <= edge_inc;
                overflow  <= ovf_inc;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench for ro_freq_counter with GATE_CYCLES=100, CNT_W=4.
// Stimulus pushes expected results; a monitor pops them on count_valid.

module tb_ro_freq_counter;

    localparam int GC  = 100;
    localparam int CW  = 4;

    typedef struct {
        logic [CW-1:0] cnt;
        logic          ovf;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ro_in = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          continuous = 1'b0;
    logic          busy;
    logic          count_valid;
    logic [CW-1:0] count_out;
    logic          overflow;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   ro_period = 10;
    logic ro_hold = 1'b0;
    int   t0;
    exp_t q[$];

    ro_freq_counter #(
        .GATE_CYCLES(GC),
        .GATE_W     (8),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ro_in      (ro_in),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .busy       (busy),
        .count_valid(count_valid),
        .count_out  (count_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act,
                         input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Ring oscillator model: period in clk cycles, 50% duty.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (ro_period == 0) begin
                ro_in = ro_hold;
            end else begin
                ph    = (ph + 1) % ro_period;
                ro_in = (ph < ro_period / 2);
            end
        end
    end

    // Monitor
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (count_valid) begin
                    check("valid_back2back", prev_valid & count_valid, 0);
                    if (q.size() == 0) begin
                        check("unexpected_valid", count_valid, 0);
                    end else begin
                        e = q.pop_front();
                        check("count_out", count_out, e.cnt);
                        check("overflow", overflow, e.ovf);
                        check("valid_cycle", cyc, e.cyc);
                    end
                end
                prev_valid = count_valid;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go(input int ecnt, input logic eovf);
        exp_t e;
        t0    = cyc;
        e.cnt = CW'(ecnt);
        e.ovf = eovf;
        e.cyc = t0 + GC + 1;
        q.push_back(e);
        pulse_start();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            check("result_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("rst_busy", busy, 0);
        check("rst_valid", count_valid, 0);
        check("rst_count", count_out, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        idle(12);

        // Basic window, period 10
        check("t1_busy_c0", busy, 0);
        go(10, 1'b0);
        check("t1_busy_c1", busy, 1);
        idle(GC);
        check("t1_busy_done", busy, 1);
        idle(1);
        check("t1_busy_after", busy, 0);
        wait_done();

        // ro_in held high: no false edge
        ro_period = 0;
        ro_hold   = 1'b1;
        idle(10);
        go(0, 1'b0);
        wait_done();

        // Saturation then recovery
        ro_period = 4;
        idle(10);
        go(15, 1'b1);
        wait_done();
        idle(2);
        check("t3_hold_count", count_out, 15);
        check("t3_hold_ovf", overflow, 1);
        ro_period = 10;
        idle(10);
        go(10, 1'b0);
        wait_done();

        // start during GATE ignored
        idle(5);
        go(10, 1'b0);
        idle(19);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        wait_done();

        // stop at cycle 50 aborts, result kept
        idle(5);
        t0 = cyc;
        pulse_start();
        idle(49);
        check("t5_cycle", cyc - t0, 50);
        stop = 1'b1;
        idle(1);
        stop = 1'b0;
        check("t5_busy_after_stop", busy, 0);
        check("t5_count_kept", count_out, 10);
        idle(GC + 20);
        check("t5_count_still", count_out, 10);

        // Continuous mode, dropped during window 3
        continuous = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            exp_t e;
            e.cnt = CW'(10);
            e.ovf = 1'b0;
            e.cyc = t0 + k * (GC + 1);
            q.push_back(e);
        end
        pulse_start();
        idle(249);
        continuous = 1'b0;
        idle(53);
        check("t4_busy_w3_done", busy, 1);
        idle(1);
        check("t4_busy_end", busy, 0);
        wait_done();
        idle(GC + 20);
        check("t4_busy_idle", busy, 0);

        // Asynchronous reset mid-window
        pulse_start();
        idle(39);
        #2;
        rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_valid", count_valid, 0);
        check("t6_count", count_out, 0);
        check("t6_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        go(10, 1'b0);
        wait_done();

        idle(5);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
